// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard scoreboard.
//   REG_AW       register address width
//   fwd_sel_t    EX operand mux select encoding
//   slot_t       per-stage tracking record {valid, wr, load, rd}
//   slot_live()  entry can forward/stall: valid, writes rd, rd != x0
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              load;
    logic [REG_AW-1:0] rd;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  function automatic logic slot_live(slot_t s);
    return s.valid & s.wr & (s.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: priority compare of one decode source register against
// the EX and MEM tracking slots.
//   src_i   source register index
//   use_i   instruction actually reads src_i
//   ex_i    slot currently in EX (will be in MEM when the reader is in EX)
//   mem_i   slot currently in MEM (will be in WB when the reader is in EX)
//   sel_o   forward select for the reader's EX cycle
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  input  slot_t             ex_i,
  input  slot_t             mem_i,
  output fwd_sel_t          sel_o
);

  // Load flags only matter for stall detection, not for forwarding.
  logic unused_load;
  assign unused_load = ex_i.load ^ mem_i.load;

  always_comb begin
    sel_o = FWD_REG;
    if (use_i && (src_i != '0)) begin
      // Youngest producer wins: EX is checked before MEM.
      if (slot_live(ex_i) && (ex_i.rd == src_i)) begin
        sel_o = FWD_EXMEM;
      end else if (slot_live(mem_i) && (mem_i.rd == src_i)) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks destinations of instructions in EX/MEM/WB,
// raises the combinational load-use stall and registers the EX-stage
// operand forward selects alongside the ID/EX pipeline register.
//   clk, reset_i (async, active low)
//   id_*_i       decode-stage instruction fields
//   flush_i      taken branch/jump in EX kills the decode instruction
//   stall_o      hold PC and IF/ID, bubble into ID/EX
//   fwd1_o/2_o   registered forward selects (00 regfile, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt_o  saturating stall-cycle counter
// Build option: define HAZARD_PERF_CNT_EN to include the stall counter;
// otherwise stall_cnt_o is tied to zero.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_wr_i,
  input  logic              id_load_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [1:0]        fwd1_o,
  output logic [1:0]        fwd2_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  slot_t    ex_q, mem_q, wb_q, ex_d;
  fwd_sel_t fwd1_q, fwd2_q;
  fwd_sel_t sel1, sel2;
  logic     stall;
  logic     bubble;

  always_comb begin
    stall = 1'b0;
    if (id_valid_i && !flush_i && slot_live(ex_q) && ex_q.load) begin
      stall = (id_use_rs1_i && (id_rs1_i == ex_q.rd)) ||
              (id_use_rs2_i && (id_rs2_i == ex_q.rd));
    end
  end

  assign bubble = !id_valid_i || stall || flush_i;

  always_comb begin
    ex_d = SLOT_BUBBLE;
    if (!bubble) begin
      ex_d.valid = 1'b1;
      ex_d.wr    = id_wr_i;
      ex_d.load  = id_load_i;
      ex_d.rd    = id_rd_i;
    end
  end

  hazard_fwd_sel u_fwd_rs1 (
    .src_i (id_rs1_i),
    .use_i (id_use_rs1_i),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_o (sel1)
  );

  hazard_fwd_sel u_fwd_rs2 (
    .src_i (id_rs2_i),
    .use_i (id_use_rs2_i),
    .ex_i  (ex_q),
    .mem_i (mem_q),
    .sel_o (sel2)
  );

  // Stages below decode never freeze, so the slots shift every cycle.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      ex_q   <= SLOT_BUBBLE;
      mem_q  <= SLOT_BUBBLE;
      wb_q   <= SLOT_BUBBLE;
      fwd1_q <= FWD_REG;
      fwd2_q <= FWD_REG;
    end else begin
      wb_q   <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= ex_d;
      fwd1_q <= bubble ? FWD_REG : sel1;
      fwd2_q <= bubble ? FWD_REG : sel2;
    end
  end

  // The WB slot retires into the register file, which the regfile read
  // path already sees, so its contents are never consulted here.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign stall_o = stall;
  assign fwd1_o  = fwd1_q;
  assign fwd2_o  = fwd2_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_o = cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_use_rs1_i, id_use_rs2_i;
  logic        id_wr_i, id_load_i, flush_i;
  logic        stall_o;
  logic [1:0]  fwd1_o, fwd2_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.CNT_W(32)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .id_valid_i   (id_valid_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .id_rd_i      (id_rd_i),
    .id_wr_i      (id_wr_i),
    .id_load_i    (id_load_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .fwd1_o       (fwd1_o),
    .fwd2_o       (fwd2_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, load, flush;
    logic       stall;
    logic [1:0] f1, f2;
  } vec_t;

  // Reference model: every instruction that actually issued, stamped with the
  // cycle it left decode. A reader decoding at cycle c sees its EX-stage
  // producer issued at c-1 and its MEM-stage producer issued at c-2.
  typedef struct {
    int         cyc;
    logic       wr, load;
    logic [4:0] rd;
  } issued_t;

  issued_t issued[$];
  int      cyc = 0;
  int      cnt_exp = 0;

  function automatic vec_t mk(logic valid, int rs1, int rs2, logic u1, logic u2,
                              int rd, logic wr, logic load, logic flush,
                              logic stall, logic [1:0] f1, logic [1:0] f2);
    vec_t v;
    v.valid = valid; v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.u1 = u1; v.u2 = u2;
    v.rd = rd[4:0]; v.wr = wr; v.load = load; v.flush = flush;
    v.stall = stall; v.f1 = f1; v.f2 = f2;
    return v;
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] src, logic use_src);
    if (!use_src || src == 5'd0) return 2'b00;
    for (int age = 1; age <= 2; age++)
      foreach (issued[i])
        if (issued[i].cyc == cyc - age && issued[i].wr && issued[i].rd == src)
          return (age == 1) ? 2'b01 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic m_stall(vec_t v);
    if (!v.valid || v.flush) return 1'b0;
    foreach (issued[i])
      if (issued[i].cyc == cyc - 1 && issued[i].wr && issued[i].load &&
          issued[i].rd != 5'd0 &&
          ((v.u1 && v.rs1 == issued[i].rd) || (v.u2 && v.rs2 == issued[i].rd)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_expected();
`ifdef HAZARD_PERF_CNT_EN
    return cnt_exp;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(vec_t v);
    id_valid_i   = v.valid;
    id_rs1_i     = v.rs1;
    id_rs2_i     = v.rs2;
    id_use_rs1_i = v.u1;
    id_use_rs2_i = v.u2;
    id_rd_i      = v.rd;
    id_wr_i      = v.wr;
    id_load_i    = v.load;
    flush_i      = v.flush;
  endtask

  // Called just after a negedge: drive decode, check the combinational stall,
  // cross the posedge, check the registered selects, advance the model.
  task automatic step(vec_t v, string name);
    issued_t e;
    drive(v);
    #1;
    chk({name, " stall"}, {31'd0, stall_o}, {31'd0, v.stall});
    @(posedge clk);
    #1;
    chk({name, " fwd1"}, {30'd0, fwd1_o}, {30'd0, v.f1});
    chk({name, " fwd2"}, {30'd0, fwd2_o}, {30'd0, v.f2});
    if (v.valid && !v.stall && !v.flush) begin
      e.cyc = cyc; e.wr = v.wr; e.load = v.load; e.rd = v.rd;
      issued.push_back(e);
    end
    if (v.stall) cnt_exp++;
    cyc++;
    while (issued.size() > 0 && issued[0].cyc < cyc - 2) void'(issued.pop_front());
    @(negedge clk);
  endtask

  vec_t tbl[18];
  vec_t nop;

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    //            vld rs1 rs2 u1 u2 rd wr ld fl  stall f1     f2
    tbl[0]  = mk(1,  1,  2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00); // add x5
    tbl[1]  = mk(1,  5,  7, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00); // sub x6,x5,x7
    tbl[2]  = mk(1,  3,  0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00); // lw x5
    tbl[3]  = mk(1,  5,  5, 1, 1, 6, 1, 0, 0, 1, 2'b00, 2'b00); // add x6,x5,x5 stalls
    tbl[4]  = mk(1,  5,  5, 1, 1, 6, 1, 0, 0, 0, 2'b10, 2'b10); // retry
    tbl[5]  = mk(1,  0,  0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00); // add x5
    tbl[6]  = nop;
    tbl[7]  = mk(1,  9,  5, 1, 1, 8, 1, 0, 0, 0, 2'b00, 2'b10); // and x8,x9,x5
    tbl[8]  = mk(1,  1,  2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00); // add x5
    tbl[9]  = mk(1,  2,  3, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00); // add x5
    tbl[10] = mk(1,  5,  0, 1, 1, 1, 1, 0, 0, 0, 2'b01, 2'b00); // or x1,x5,x0
    tbl[11] = mk(1,  0,  0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00); // write x0
    tbl[12] = mk(1,  0,  0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00); // read x0
    tbl[13] = mk(1,  0,  0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00); // lw x0
    tbl[14] = mk(1,  0,  0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00); // read x0
    tbl[15] = mk(1,  2,  0, 1, 0, 5, 1, 1, 0, 0, 2'b00, 2'b00); // lw x5
    tbl[16] = mk(1,  5,  5, 1, 1, 6, 1, 0, 1, 0, 2'b00, 2'b00); // consumer, flushed
    tbl[17] = mk(1,  5,  0, 1, 0, 7, 1, 0, 0, 0, 2'b10, 2'b00); // add x7,x5,x0

    reset_i = 1'b0;
    drive(nop);
    @(negedge clk);
    @(negedge clk);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    chk("reset fwd1", {30'd0, fwd1_o}, 32'd0);
    chk("reset fwd2", {30'd0, fwd2_o}, 32'd0);
    chk("reset cnt", stall_cnt_o, 32'd0);
    reset_i = 1'b1;

    foreach (tbl[i]) step(tbl[i], $sformatf("tbl[%0d]", i));
    chk("tbl cnt", stall_cnt_o, cnt_expected());

    for (int n = 0; n < 2000; n++) begin
      vec_t v;
      v.valid = ($urandom_range(0, 7) != 0);
      v.rs1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 7));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 7));
      v.wr    = ($urandom_range(0, 3) != 0);
      v.load  = ($urandom_range(0, 2) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.stall = m_stall(v);
      if (!v.valid || v.flush || v.stall) begin
        v.f1 = 2'b00;
        v.f2 = 2'b00;
      end else begin
        v.f1 = m_fwd(v.rs1, v.u1);
        v.f2 = m_fwd(v.rs2, v.u2);
      end
      step(v, $sformatf("rnd[%0d]", n));
    end
    chk("rnd cnt", stall_cnt_o, cnt_expected());

    // Reset mid-stream with a live load in EX and a stalled consumer.
    step(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00), "pre add x5");
    step(mk(1, 5, 0, 1, 0, 7, 1, 1, 0, 0, 2'b01, 2'b00), "pre lw x7,x5");
    drive(mk(1, 7, 7, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00));
    #1;
    chk("pre-reset stall", {31'd0, stall_o}, 32'd1);
    #1;
    reset_i = 1'b0;
    #1;
    chk("mid reset stall", {31'd0, stall_o}, 32'd0);
    chk("mid reset fwd1", {30'd0, fwd1_o}, 32'd0);
    chk("mid reset fwd2", {30'd0, fwd2_o}, 32'd0);
    chk("mid reset cnt", stall_cnt_o, 32'd0);
    issued.delete();
    cnt_exp = 0;
    @(negedge clk);
    reset_i = 1'b1;
    step(mk(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 2'b00, 2'b00), "post reset x5,x7");
    chk("post reset cnt", stall_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
